// File: rtl/s3g_pkg.sv
// s3g_pkg: constants, CRC-8 helper and transmitter state encoding for the
// S3G serial protocol. Used by s3g_tx, s3g_crc8, s3g_rx and the executor.
package s3g_pkg;

   localparam logic [7:0]  S3G_START       = 8'hD5;
   localparam int unsigned S3G_MAX_PAYLOAD = 16;
   localparam logic [7:0]  S3G_CRC_POLY    = 8'h8C;

   // Maxim/iButton CRC-8, reflected, LSB-first: fold one byte into crc.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                            input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ S3G_CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_LEN,
      S_PAYLOAD,
      S_CRC
   } s3g_tx_state_e;

endpackage

// File: rtl/s3g_crc8.sv
// s3g_crc8: registered S3G CRC-8 accumulator.
// Ports: clk, rst (sync, active-high), clr (restart at 0x00),
//        en (fold data into crc), data[7:0], crc[7:0] (current value).
module s3g_crc8
   import s3g_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] data,
   output logic [7:0] crc
);

   logic [7:0] crc_q;
   logic [7:0] crc_d;

   // clr wins over en so a new frame always starts from 0x00.
   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = 8'h00;
      end else if (en) begin
         crc_d = crc8_byte(crc_q, data);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= 8'h00;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/s3g_tx.sv
// s3g_tx: S3G packet transmitter. Latches a response (length + up to 16
// payload bytes) on packet_wr and serialises D5, len, payload, CRC-8 onto a
// byte-wide UART with a one-cycle gap between write strobes.
// Ports: clk, rst (sync, active-high); packet_wr, payload_len, buf0..buf15
//        from the executor; busy back to the executor; uart_data, uart_wr,
//        uart_busy to/from the UART.
// Optional: define S3G_TX_STATS_EN to add pkt_count (completed frames,
//        wrapping) and drop_count (ignored strobes, saturating).
// uart_wr/uart_data are combinational from registered state and uart_busy so
// a byte can go out in the same cycle the UART reports ready.
module s3g_tx
   import s3g_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD = S3G_MAX_PAYLOAD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        packet_wr,
   input  logic [7:0]  payload_len,
   input  logic [7:0]  buf0,
   input  logic [7:0]  buf1,
   input  logic [7:0]  buf2,
   input  logic [7:0]  buf3,
   input  logic [7:0]  buf4,
   input  logic [7:0]  buf5,
   input  logic [7:0]  buf6,
   input  logic [7:0]  buf7,
   input  logic [7:0]  buf8,
   input  logic [7:0]  buf9,
   input  logic [7:0]  buf10,
   input  logic [7:0]  buf11,
   input  logic [7:0]  buf12,
   input  logic [7:0]  buf13,
   input  logic [7:0]  buf14,
   input  logic [7:0]  buf15,
   output logic        busy,
   output logic [7:0]  uart_data,
   output logic        uart_wr,
   input  logic        uart_busy
`ifdef S3G_TX_STATS_EN
   ,
   output logic [15:0] pkt_count,
   output logic [7:0]  drop_count
`endif
);

   localparam int unsigned LEN_W = $clog2(MAX_PAYLOAD + 1);
   localparam int unsigned IDX_W = $clog2(MAX_PAYLOAD);

   s3g_tx_state_e    state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [7:0]       pay_q [MAX_PAYLOAD];
   logic [7:0]       pay_d [MAX_PAYLOAD];
   logic             wr_prev_q, wr_prev_d;

   logic [LEN_W-1:0] len_clamp;
   logic             can_send;
   logic [7:0]       data_c;
   logic             crc_clr;
   logic             crc_en;
   logic [7:0]       crc;

`ifdef S3G_TX_STATS_EN
   logic [15:0] pkt_q, pkt_d;
   logic [7:0]  drop_q, drop_d;
`endif

   s3g_crc8 u_crc (
      .clk  (clk),
      .rst  (rst),
      .clr  (crc_clr),
      .en   (crc_en),
      .data (data_c),
      .crc  (crc)
   );

   assign len_clamp = (payload_len > 8'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD)
                                                     : LEN_W'(payload_len);

   // A byte may go out only when the UART is free and no strobe was issued
   // last cycle; the gap hides the UART's busy-rise latency. rst kills it.
   assign can_send = (state_q != S_IDLE) && !uart_busy && !wr_prev_q && !rst;

   // Next-state, datapath and UART strobe.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      pay_d     = pay_q;
      data_c    = 8'h00;
      crc_clr   = 1'b0;
      crc_en    = 1'b0;
      wr_prev_d = can_send;

      unique case (state_q)
         S_IDLE: begin
            if (packet_wr) begin
               len_d   = len_clamp;
               idx_d   = '0;
               crc_clr = 1'b1;
               pay_d[0]  = buf0;  pay_d[1]  = buf1;
               pay_d[2]  = buf2;  pay_d[3]  = buf3;
               pay_d[4]  = buf4;  pay_d[5]  = buf5;
               pay_d[6]  = buf6;  pay_d[7]  = buf7;
               pay_d[8]  = buf8;  pay_d[9]  = buf9;
               pay_d[10] = buf10; pay_d[11] = buf11;
               pay_d[12] = buf12; pay_d[13] = buf13;
               pay_d[14] = buf14; pay_d[15] = buf15;
               state_d = S_START;
            end
         end
         S_START: begin
            data_c = S3G_START;
            if (can_send) state_d = S_LEN;
         end
         S_LEN: begin
            data_c = 8'(len_q);
            if (can_send) state_d = (len_q != '0) ? S_PAYLOAD : S_CRC;
         end
         S_PAYLOAD: begin
            data_c = pay_q[idx_q];
            crc_en = can_send;
            if (can_send) begin
               idx_d = idx_q + IDX_W'(1);
               if (LEN_W'(idx_q) == len_q - LEN_W'(1)) state_d = S_CRC;
            end
         end
         S_CRC: begin
            data_c = crc;
            if (can_send) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef S3G_TX_STATS_EN
   // Frame counter wraps; drop counter saturates.
   always_comb begin
      pkt_d  = pkt_q;
      drop_d = drop_q;
      if (state_q == S_CRC && can_send) pkt_d = pkt_q + 16'd1;
      if (packet_wr && state_q != S_IDLE && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         len_q     <= '0;
         wr_prev_q <= 1'b0;
         for (int i = 0; i < int'(MAX_PAYLOAD); i++) pay_q[i] <= 8'h00;
`ifdef S3G_TX_STATS_EN
         pkt_q     <= 16'd0;
         drop_q    <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         wr_prev_q <= wr_prev_d;
         pay_q     <= pay_d;
`ifdef S3G_TX_STATS_EN
         pkt_q     <= pkt_d;
         drop_q    <= drop_d;
`endif
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign uart_wr   = can_send;
   assign uart_data = data_c;

`ifdef S3G_TX_STATS_EN
   assign pkt_count  = pkt_q;
   assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_s3g_tx.sv
// tb_s3g_tx: directed self-checking bench for s3g_tx. A monitor captures every
// UART byte with its cycle offset from the accepting packet_wr; frames are
// compared against hand-computed bytes and a bench-side CRC model.
module tb_s3g_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        packet_wr;
   logic [7:0]  payload_len;
   logic [7:0]  bufs [16];
   logic        busy;
   logic [7:0]  uart_data;
   logic        uart_wr;
   logic        uart_busy;
`ifdef S3G_TX_STATS_EN
   logic [15:0] pkt_count;
   logic [7:0]  drop_count;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          t0    = 0;
   int          last_fall = 0;
   bit          stall_en = 1'b0;
   bit          prev_wr  = 1'b0;
   logic [7:0]  pay [16];
   logic [7:0]  rx_q [$];
   int          cyc_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   s3g_tx dut (
      .clk        (clk),
      .rst        (rst),
      .packet_wr  (packet_wr),
      .payload_len(payload_len),
      .buf0 (bufs[0]),  .buf1 (bufs[1]),  .buf2 (bufs[2]),  .buf3 (bufs[3]),
      .buf4 (bufs[4]),  .buf5 (bufs[5]),  .buf6 (bufs[6]),  .buf7 (bufs[7]),
      .buf8 (bufs[8]),  .buf9 (bufs[9]),  .buf10(bufs[10]), .buf11(bufs[11]),
      .buf12(bufs[12]), .buf13(bufs[13]), .buf14(bufs[14]), .buf15(bufs[15]),
      .busy       (busy),
      .uart_data  (uart_data),
      .uart_wr    (uart_wr),
      .uart_busy  (uart_busy)
`ifdef S3G_TX_STATS_EN
      ,
      .pkt_count  (pkt_count),
      .drop_count (drop_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Classic Maxim CRC-8 (bit-serial, mix-bit form) over pay[0..n-1].
   function automatic logic [7:0] crc_model(input int n);
      logic [7:0] c = 8'h00;
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = pay[i];
         for (int k = 0; k < 8; k++) begin
            logic mix;
            mix = c[0] ^ b[0];
            c   = c >> 1;
            if (mix) c = c ^ 8'h8C;
            b   = b >> 1;
         end
      end
      return c;
   endfunction

   // UART monitor: capture bytes, enforce gap and busy rules.
   initial begin
      forever begin
         @(negedge clk);
         if (uart_wr) begin
            check("wr_while_uart_busy", 32'(uart_busy), 32'd0);
            check("wr_adjacent", 32'(prev_wr), 32'd0);
            rx_q.push_back(uart_data);
            cyc_q.push_back(cyc - t0);
         end
         prev_wr = uart_wr;
      end
   end

   // UART busy generator: random stalls when enabled.
   initial begin
      uart_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         uart_busy = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   // Launch a frame from pay/len, optionally strobe packet_wr again with junk
   // at cycle drop_at, wait for busy to fall, then compare the byte stream.
   task automatic run_frame(input logic [7:0] len, input int drop_at, input string tag);
      int n;
      bit done;
      logic [7:0] exp [$];
      rx_q.delete();
      cyc_q.delete();
      @(posedge clk);
      #1;
      payload_len = len;
      for (int i = 0; i < 16; i++) bufs[i] = pay[i];
      packet_wr = 1'b1;
      t0 = cyc;
      done = 1'b0;
      for (int c = 1; c <= 400 && !done; c++) begin
         @(posedge clk);
         #1;
         packet_wr = (c == drop_at);
         if (c == drop_at) begin
            payload_len = 8'd2;
            for (int i = 0; i < 16; i++) bufs[i] = 8'hEE;
         end
         @(negedge clk);
         if (c == 1) check({tag, "_busy_c1"}, 32'(busy), 32'd1);
         if (!busy) begin
            done = 1'b1;
            last_fall = c;
         end
      end
      packet_wr = 1'b0;
      if (!done) check({tag, "_timeout"}, 32'd1, 32'd0);
      n = (len > 8'd16) ? 16 : int'(len);
      exp.push_back(8'hD5);
      exp.push_back(8'(n));
      for (int i = 0; i < n; i++) exp.push_back(pay[i]);
      exp.push_back(crc_model(n));
      check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp[i]));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      packet_wr = 1'b0;
      payload_len = 8'd0;
      for (int i = 0; i < 16; i++) begin
         bufs[i] = 8'h00;
         pay[i]  = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_uart_wr", 32'(uart_wr), 32'd0);
      check("rst_uart_data", 32'(uart_data), 32'd0);
`ifdef S3G_TX_STATS_EN
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
      check("rst_drop_count", 32'(drop_count), 32'd0);
`endif

      // len=1, 0x81: D5 01 81 D2 at cycles 1,3,5,7; busy falls at 8.
      pay[0] = 8'h81;
      run_frame(8'd1, 0, "l1_81");
      if (rx_q.size() == 4) begin
         check("l1_81_crc_hand", 32'(rx_q[3]), 32'hD2);
         for (int i = 0; i < 4; i++)
            check($sformatf("l1_81_cyc%0d", i), 32'(cyc_q[i]), 32'(2 * i + 1));
      end
      check("l1_81_busy_fall", 32'(last_fall), 32'd8);

      // len=1, 0x80 -> CRC 0x8C; then empty frame D5 00 00.
      pay[0] = 8'h80;
      run_frame(8'd1, 0, "l1_80");
      if (rx_q.size() == 4) check("l1_80_crc_hand", 32'(rx_q[3]), 32'h8C);
      run_frame(8'd0, 0, "l0");
      if (rx_q.size() == 3) begin
         check("l0_crc_hand", 32'(rx_q[2]), 32'h00);
         check("l0_cyc_crc", 32'(cyc_q[2]), 32'd5);
      end
      check("l0_busy_fall", 32'(last_fall), 32'd6);

      // Oversized length clamps to 16.
      for (int i = 0; i < 16; i++) pay[i] = 8'(i);
      run_frame(8'd20, 0, "l20");
      if (rx_q.size() == 19) check("l20_len_hand", 32'(rx_q[1]), 32'h10);

      // Random UART stalls.
      stall_en = 1'b1;
      for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
      run_frame(8'd16, 0, "stall16");
      for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
      run_frame(8'd5, 0, "stall5");
      stall_en = 1'b0;

      // Strobes while busy are ignored, including in the final write cycle.
      do_reset();
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      run_frame(8'd3, 4, "drop_mid");
      run_frame(8'd0, 5, "drop_last");
      check("drop_last_busy_fall", 32'(last_fall), 32'd6);
`ifdef S3G_TX_STATS_EN
      check("stats_drop_count", 32'(drop_count), 32'd2);
      check("stats_pkt_count", 32'(pkt_count), 32'd2);
`endif

      // Reset after the length byte aborts the frame.
      rx_q.delete();
      cyc_q.delete();
      for (int i = 0; i < 4; i++) pay[i] = 8'hA0 + 8'(i);
      @(posedge clk);
      #1;
      payload_len = 8'd4;
      for (int i = 0; i < 16; i++) bufs[i] = pay[i];
      packet_wr = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1;
      packet_wr = 1'b0;
      for (int c = 0; c < 20 && rx_q.size() < 2; c++) @(negedge clk);
      check("abort_two_bytes", 32'(rx_q.size()), 32'd2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("abort_wr_in_rst", 32'(uart_wr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (10) @(negedge clk);
      check("abort_no_more_bytes", 32'(rx_q.size()), 32'd2);
      for (int i = 0; i < 4; i++) pay[i] = 8'h5A ^ 8'(i);
      run_frame(8'd4, 0, "after_abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/s3g_tx.md
# s3g_tx

S3G packet transmitter: accepts a parallel response (length plus up to 16 payload bytes) from the executor in one strobe and serialises it as an S3G frame (start byte, length, payload, CRC-8) onto the byte-wide UART transmitter. It sits between the executor's `tx_*` outputs and the UART. It provides the `tx_busy` signal that the executor waits on between responses.

## Interface
Parameters:
- `MAX_PAYLOAD`, 16, payload bytes accepted per frame; fixed at 16 to match `buf0..buf15`.

Ports (clock/reset: one clock, reset synchronous active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `packet_wr`  in  1  one-cycle strobe; latch `payload_len`, `buf0..buf15`
- `payload_len`  in  8  payload byte count
- `buf0`..`buf15`  in  8 each  payload bytes, `buf0` sent first
- `busy`  out  1  frame in progress; drives executor `tx_busy`
- `uart_data`  out  8  byte to UART
- `uart_wr`  out  1  one-cycle write strobe to UART
- `uart_busy`  in  1  UART cannot accept a byte
- `pkt_count`  out  16  completed frames (only with `S3G_TX_STATS_EN`)
- `drop_count`  out  8  ignored strobes (only with `S3G_TX_STATS_EN`)

## Operation
- Frame: 0xD5, len, payload[0..len-1], crc. The CRC is Maxim/iButton CRC-8 over the payload only, init 0x00, reflected poly 0x8C, LSB-first: per bit, if crc[0] then crc=(crc>>1)^0x8C else crc>>=1, after crc^=byte.
- `payload_len` > 16 is clamped to 16; the length byte sent is the clamped value.
- len=0 is legal: the frame is D5 00 00.
- States:
  - S_IDLE: on `packet_wr`, latch the inputs, clear the CRC, and go to S_START.
  - S_START: send 0xD5, then go to S_LEN.
  - S_LEN: send len. Go to S_PAYLOAD if len≠0, else to S_CRC.
  - S_PAYLOAD: send byte[idx] and fold it into the CRC. Increment idx; after idx==len-1, go to S_CRC.
  - S_CRC: send the final CRC and go to S_IDLE.
- UART byte handshake:
  - `uart_wr` is asserted only in a cycle where `uart_busy`=0 and `uart_wr` was 0 in the previous cycle, giving a mandatory one-cycle gap that covers the UART's busy-rise latency.
  - `uart_data` is valid in the `uart_wr` cycle.
  - The state advances in the same cycle as `uart_wr`.
- A `packet_wr` while `busy`=1 is ignored; the frame in flight is unaffected.
- Latched payload registers are internal; inputs may change freely after the strobe.

## Timing
- Reset values: `busy`=0, `uart_wr`=0, `uart_data`=0x00, state S_IDLE, stats counters 0.
- `packet_wr` at cycle 0 → `busy`=1 from cycle 1.
- First `uart_wr` (0xD5) occurs no earlier than cycle 1.
- Minimum 2 cycles per byte. With `uart_busy` held at 0, a len-N frame uses `uart_wr` at cycles 1,3,…,2N+5.
- `busy` falls in the cycle after the CRC byte's `uart_wr`.
- A `packet_wr` in that same cycle, or later, is accepted.
- `packet_wr` in the cycle of the final `uart_wr` is ignored (`busy` still 1).
- `rst` mid-frame aborts immediately: no further `uart_wr`, state S_IDLE next cycle, latched data discarded.
- `uart_busy` may stay high indefinitely; the block holds state and keeps `busy`=1.

## Configuration
- `S3G_TX_STATS_EN` defined:
  - `pkt_count` increments at each CRC-byte `uart_wr` and wraps at 0xFFFF→0.
  - `drop_count` increments on each ignored `packet_wr` and saturates at 0xFF.
  - Both are cleared by `rst`.
- Undefined: both ports and their counters are absent; framing behaviour is identical.

## Structure
- Shared package `s3g_pkg`:
  - `S3G_START` = 8'hD5, `S3G_MAX_PAYLOAD` = 16, `S3G_CRC_POLY` = 8'h8C.
  - Function `crc8_byte(crc, data)`.
  - State enum for this block.
- The executor and `s3g_rx` reuse the constants and CRC function.
- Sub-module `s3g_crc8`: registered CRC with `clr`, `en`, `data[7:0]`, `crc[7:0]`; instantiated once here and reusable by the receiver.

## Test plan
- len=1, buf0=0x81, `uart_busy`=0 → `uart_wr` bytes D5 01 81 D2, at cycles 1,3,5,7; `busy` 1→0 at cycle 8.
- len=1, buf0=0x80 → D5 01 80 8C; then len=0 → D5 00 00.
- len=20, buf0..15 = 0x00..0x0F → length byte 0x10, 16 payload bytes, CRC matching the software model.
- `uart_busy` toggled randomly with a 0–5 cycle stall per byte → byte order and values unchanged, never two `uart_wr` in adjacent cycles, no `uart_wr` while `uart_busy`=1.
- `packet_wr` pulsed mid-frame → no effect on the frame; `drop_count`=1 with `S3G_TX_STATS_EN`; `pkt_count`=1 after completion.
- `rst` asserted after the length byte → no further `uart_wr`, `busy`=0 next cycle, next `packet_wr` produces a clean full frame.
